decode_dispatch_queue: RTL and testbench



---
 rtl/decode_dispatch_queue.sv | 123 ++++++++++++
 tb/tb_decode_dispatch_queue.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/decode_dispatch_queue.sv
// Decode-to-dispatch micro-op FIFO with wrapping sequence tags, a cap on resident branches
// and whole-queue flush for mispredict recovery.
module decode_dispatch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned UOP_W    = 32,
    parameter int unsigned TAG_W    = 4,
    parameter int unsigned BR_LIMIT = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush_i,
    input  logic                       enq_valid_i,
    input  logic [UOP_W-1:0]           enq_uop_i,
    input  logic                       enq_branch_i,
    output logic                       enq_ready_o,
    output logic                       enq_br_stall_o,
    output logic                       deq_valid_o,
    output logic [UOP_W-1:0]           deq_uop_o,
    output logic [TAG_W-1:0]           deq_tag_o,
    output logic                       deq_branch_o,
    input  logic                       deq_ready_i,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic [$clog2(BR_LIMIT):0]  br_count_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned BrW  = $clog2(BR_LIMIT) + 1;

    logic [PtrW-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CntW-1:0]  count_q, count_d;
    logic [BrW-1:0]   br_count_q, br_count_d;
    logic [TAG_W-1:0] next_tag_q, next_tag_d;
    logic [UOP_W-1:0] uop_q [DEPTH];
    logic [UOP_W-1:0] uop_d [DEPTH];
    logic [TAG_W-1:0] tag_q [DEPTH];
    logic [TAG_W-1:0] tag_d [DEPTH];
    logic [DEPTH-1:0] br_q, br_d;

    logic br_ok, push, pop, push_br, pop_br;

    assign enq_ready_o    = (count_q < CntW'(DEPTH));
    assign deq_valid_o    = (count_q != '0);
    assign deq_uop_o      = uop_q[head_q];
    assign deq_tag_o      = tag_q[head_q];
    assign deq_branch_o   = br_q[head_q];
    assign count_o        = count_q;
    assign br_count_o     = br_count_q;

    // Branch admission uses pre-pop occupancy, so a same-cycle branch pop cannot free a slot.
    assign br_ok          = (br_count_q < BrW'(BR_LIMIT));
    assign enq_br_stall_o = enq_valid_i & enq_branch_i & enq_ready_o & ~br_ok;

    assign push    = enq_valid_i & enq_ready_o & (~enq_branch_i | br_ok) & ~flush_i;
    assign pop     = deq_valid_o & deq_ready_i & ~flush_i;
    assign push_br = push & enq_branch_i;
    assign pop_br  = pop & deq_branch_o;

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        br_count_d = br_count_q;
        next_tag_d = next_tag_q;
        uop_d      = uop_q;
        tag_d      = tag_q;
        br_d       = br_q;

        if (flush_i) begin
            // next_tag keeps running so tags stay unique across the flush.
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            br_count_d = '0;
        end else begin
            if (push) begin
                uop_d[tail_q] = enq_uop_i;
                tag_d[tail_q] = next_tag_q;
                br_d[tail_q]  = enq_branch_i;
                tail_d        = tail_q + PtrW'(1);
                next_tag_d    = next_tag_q + TAG_W'(1);
            end
            if (pop) begin
                head_d = head_q + PtrW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CntW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CntW'(1);
            end
            if (push_br && !pop_br) begin
                br_count_d = br_count_q + BrW'(1);
            end else if (pop_br && !push_br) begin
                br_count_d = br_count_q - BrW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            br_count_q <= '0;
            next_tag_q <= '0;
            br_q       <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            br_count_q <= br_count_d;
            next_tag_q <= next_tag_d;
            br_q       <= br_d;
        end
    end

    // Payload and tag storage carry no reset.
    always_ff @(posedge clk) begin
        uop_q <= uop_d;
        tag_q <= tag_d;
    end

endmodule

// File: tb/tb_decode_dispatch_queue.sv
// Self-checking bench for decode_dispatch_queue: vector table plus queue-model scoreboard
// and directed multi-cycle sequences.
module tb_decode_dispatch_queue;

    logic        clk = 1'b0;
    logic        reset, flush_i, enq_valid_i, enq_branch_i, deq_ready_i;
    logic [31:0] enq_uop_i;
    logic        enq_ready_o, enq_br_stall_o, deq_valid_o, deq_branch_o;
    logic [31:0] deq_uop_o;
    logic [3:0]  deq_tag_o;
    logic [2:0]  count_o;
    logic [1:0]  br_count_o;

    decode_dispatch_queue #(
        .DEPTH(4), .UOP_W(32), .TAG_W(4), .BR_LIMIT(2)
    ) dut (
        .clk(clk), .reset(reset), .flush_i(flush_i),
        .enq_valid_i(enq_valid_i), .enq_uop_i(enq_uop_i), .enq_branch_i(enq_branch_i),
        .enq_ready_o(enq_ready_o), .enq_br_stall_o(enq_br_stall_o),
        .deq_valid_o(deq_valid_o), .deq_uop_o(deq_uop_o), .deq_tag_o(deq_tag_o),
        .deq_branch_o(deq_branch_o), .deq_ready_i(deq_ready_i),
        .count_o(count_o), .br_count_o(br_count_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] uop;
        logic [3:0]  tag;
        logic        br;
    } ent_t;

    typedef struct {
        logic        ev;
        logic [31:0] uop;
        logic        br;
        logic        dr;
        logic [2:0]  cnt;
        logic        rdy;
    } vec_t;

    ent_t sb[$];
    int   m_br;
    int   m_tag;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic ev, input logic [31:0] uop, input logic br,
                         input logic dr, input logic fl, input logic rst);
        enq_valid_i  = ev;
        enq_uop_i    = uop;
        enq_branch_i = br;
        deq_ready_i  = dr;
        flush_i      = fl;
        reset        = rst;
    endtask

    // Check outputs against the model just before the edge, then advance model and DUT.
    task automatic cycle();
        logic push_ok, pop_ok;
        int   cnt;
        ent_t e;
        @(negedge clk);
        cnt = sb.size();
        chk("enq_ready", enq_ready_o, cnt < 4);
        chk("deq_valid", deq_valid_o, cnt != 0);
        chk("count", count_o, cnt);
        chk("br_count", br_count_o, m_br);
        chk("br_stall", enq_br_stall_o,
            enq_valid_i & enq_branch_i & (cnt < 4) & (m_br >= 2));
        push_ok = enq_valid_i && cnt < 4 && (!enq_branch_i || m_br < 2) && !flush_i;
        pop_ok  = cnt != 0 && deq_ready_i && !flush_i;
        if (reset) begin
            sb.delete();
            m_br  = 0;
            m_tag = 0;
        end else if (flush_i) begin
            sb.delete();
            m_br = 0;
        end else begin
            if (pop_ok) begin
                e = sb.pop_front();
                chk("deq_uop", deq_uop_o, e.uop);
                chk("deq_tag", deq_tag_o, e.tag);
                chk("deq_branch", deq_branch_o, e.br);
                if (e.br) m_br--;
            end
            if (push_ok) begin
                e.uop = enq_uop_i;
                e.tag = m_tag[3:0];
                e.br  = enq_branch_i;
                sb.push_back(e);
                m_tag = (m_tag + 1) % 16;
                if (enq_branch_i) m_br++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
        m_br  = 0;
        m_tag = 0;
    endtask

    task automatic drain();
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) cycle();
    endtask

    vec_t vecs[8];

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{1'b1, 32'hA0, 1'b0, 1'b0, 3'd1, 1'b1};
        vecs[1] = '{1'b1, 32'hA1, 1'b0, 1'b0, 3'd2, 1'b1};
        vecs[2] = '{1'b1, 32'hA2, 1'b0, 1'b0, 3'd3, 1'b1};
        vecs[3] = '{1'b1, 32'hA3, 1'b0, 1'b0, 3'd4, 1'b0};
        // Full: push refused even though a pop happens this cycle.
        vecs[4] = '{1'b1, 32'hA4, 1'b0, 1'b1, 3'd3, 1'b1};
        vecs[5] = '{1'b0, 32'h00, 1'b0, 1'b1, 3'd2, 1'b1};
        vecs[6] = '{1'b0, 32'h00, 1'b0, 1'b1, 3'd1, 1'b1};
        vecs[7] = '{1'b0, 32'h00, 1'b0, 1'b1, 3'd0, 1'b1};

        do_reset();
        chk("rst_enq_ready", enq_ready_o, 1);
        chk("rst_deq_valid", deq_valid_o, 0);
        chk("rst_count", count_o, 0);
        chk("rst_br_count", br_count_o, 0);

        // Fill then drain, table driven.
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].ev, vecs[i].uop, vecs[i].br, vecs[i].dr, 1'b0, 1'b0);
            cycle();
            chk($sformatf("vec%0d_count", i), count_o, vecs[i].cnt);
            chk($sformatf("vec%0d_ready", i), enq_ready_o, vecs[i].rdy);
        end
        chk("fill_empty_valid", deq_valid_o, 0);

        // Streaming: one push and one pop per cycle, tags wrap past 15.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 32'h100 + i, 1'b0, 1'b1, 1'b0, 1'b0);
            cycle();
            chk($sformatf("stream%0d_count", i), count_o, 1);
            chk($sformatf("stream%0d_tag", i), deq_tag_o, i % 16);
        end
        drain();

        // Branch cap and branch churn.
        do_reset();
        drive(1'b1, 32'hB0, 1'b1, 1'b0, 1'b0, 1'b0); cycle();
        drive(1'b1, 32'hB1, 1'b1, 1'b0, 1'b0, 1'b0); cycle();
        drive(1'b1, 32'hB2, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        chk("cap_stall", enq_br_stall_o, 1);
        cycle();
        chk("cap_br_count", br_count_o, 2);
        chk("cap_count", count_o, 2);
        drive(1'b1, 32'hB2, 1'b1, 1'b1, 1'b0, 1'b0); cycle();
        chk("churn_br_count", br_count_o, 1);
        chk("churn_count", count_o, 1);
        drive(1'b1, 32'hB2, 1'b1, 1'b0, 1'b0, 1'b0); cycle();
        chk("cap_accept_br", br_count_o, 2);
        chk("cap_accept_count", count_o, 2);
        drain();

        // Flush with 3 queued and next tag 7.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'hC0 + i, 1'b0, 1'b0, 1'b0, 1'b0); cycle();
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0); cycle();
        end
        drive(1'b1, 32'hD4, 1'b1, 1'b0, 1'b0, 1'b0); cycle();
        drive(1'b1, 32'hD5, 1'b1, 1'b0, 1'b0, 1'b0); cycle();
        drive(1'b1, 32'hD6, 1'b0, 1'b0, 1'b0, 1'b0); cycle();
        chk("pre_flush_count", count_o, 3);
        drive(1'b1, 32'hDF, 1'b0, 1'b1, 1'b1, 1'b0); cycle();
        chk("flush_count", count_o, 0);
        chk("flush_br_count", br_count_o, 0);
        chk("flush_deq_valid", deq_valid_o, 0);
        drive(1'b1, 32'hE7, 1'b0, 1'b0, 1'b0, 1'b0); cycle();
        chk("post_flush_valid", deq_valid_o, 1);
        chk("post_flush_tag", deq_tag_o, 7);
        chk("post_flush_uop", deq_uop_o, 32'hE7);
        drain();

        // Reset mid-stream overrides flush.
        drive(1'b1, 32'hF0, 1'b1, 1'b0, 1'b0, 1'b0); cycle();
        drive(1'b1, 32'hF1, 1'b0, 1'b0, 1'b0, 1'b0); cycle();
        drive(1'b1, 32'hF2, 1'b0, 1'b1, 1'b1, 1'b1); cycle();
        reset = 1'b0;
        chk("mrst_count", count_o, 0);
        chk("mrst_br_count", br_count_o, 0);
        chk("mrst_ready", enq_ready_o, 1);
        chk("mrst_valid", deq_valid_o, 0);
        drive(1'b1, 32'hF3, 1'b0, 1'b0, 1'b0, 1'b0); cycle();
        chk("mrst_tag", deq_tag_o, 0);
        drain();

        // Random traffic against the scoreboard.
        for (int i = 0; i < 200; i++) begin
            drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0), 1'b0);
            cycle();
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
